ysyx_24120013_ifu: RTL and testbench

- Instruction fetch unit; sits directly upstream of the decode stage.
- Owns the PC and issues one word-aligned fetch at a time to instruction memory over a valid/ready request and a valid-only response.
- Presents the fetched 32-bit instruction and its PC to decode with a valid/ready handshake.
- Accepts a redirect (branch/jump target) from execute, which flushes any in-flight fetch.

---
 rtl/ysyx_24120013_ifu_pkg.sv | 7 +
 rtl/ysyx_24120013_ifu_perf.sv | 19 +
 rtl/ysyx_24120013_ifu.sv | 84 ++++++++
 tb/tb_ysyx_24120013_ifu.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24120013_ifu_pkg.sv
// ysyx_24120013_ifu_pkg: shared state encoding and constants for the instruction fetch unit
package ysyx_24120013_ifu_pkg;
  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_OUT} state_t;
  localparam int INST_WIDTH = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;
endpackage

// File: rtl/ysyx_24120013_ifu_perf.sv
// ysyx_24120013_ifu_perf: retired-fetch and stall-cycle counters, wrapping at 2^32
module ysyx_24120013_ifu_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fire,
  input  logic        stall,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + {31'd0, fire};
      stall_cnt <= stall_cnt + {31'd0, stall};
    end
  end
endmodule

// File: rtl/ysyx_24120013_ifu.sv
// ysyx_24120013_ifu: single-outstanding fetch unit with redirect flush; IFU_PERF_CNT_EN adds perf counters
module ysyx_24120013_ifu
  import ysyx_24120013_ifu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEF_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] pc, pc_nx;
  logic [INST_WIDTH-1:0] inst_buf;
  logic drop, drop_nx, load;
  always_comb begin
    state_nx = state;
    drop_nx  = drop;
    load     = 1'b0;
    pc_nx    = redirect_valid ? (redirect_pc & ~ADDR_WIDTH'(3)) :
               (state == S_OUT && inst_ready) ? pc + ADDR_WIDTH'(PC_STEP) : pc;
    case (state)
      S_BOOT: state_nx = S_REQ;
      S_REQ: begin
        state_nx = imem_req_ready ? S_WAIT : S_REQ;
        drop_nx  = redirect_valid && imem_req_ready;
      end
      S_WAIT: begin
        // a response for a flushed request returns to S_REQ without touching the buffer
        state_nx = !imem_resp_valid ? S_WAIT : (drop || redirect_valid) ? S_REQ : S_OUT;
        load     = imem_resp_valid && !drop && !redirect_valid;
        drop_nx  = !imem_resp_valid && (drop || redirect_valid);
      end
      S_OUT: state_nx = (redirect_valid || inst_ready) ? S_REQ : S_OUT;
      default: state_nx = S_BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_BOOT;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      inst_buf <= '0;
      inst_pc  <= '0;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      drop  <= drop_nx;
      if (load) begin
        inst_buf <= imem_resp_data;
        inst_pc  <= pc;
      end
    end
  end
  assign imem_req_valid = state == S_REQ;
  assign imem_req_addr  = imem_req_valid ? pc : '0;
  assign inst_valid     = state == S_OUT;
  assign inst           = inst_buf;
`ifdef IFU_PERF_CNT_EN
  ysyx_24120013_ifu_perf u_perf (
    .clk      (clk),
    .rst      (rst),
    .fire     (inst_valid && inst_ready && !redirect_valid),
    .stall    (state == S_WAIT || (state == S_OUT && !inst_ready)),
    .fetch_cnt(perf_fetch_cnt),
    .stall_cnt(perf_stall_cnt)
  );
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_ysyx_24120013_ifu.sv
// tb_ysyx_24120013_ifu: scoreboard bench with a memory model and an architectural PC reference
module tb_ysyx_24120013_ifu;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  logic clk = 1'b0, rst = 1'b0;
  logic imem_req_valid, imem_req_ready, imem_resp_valid, inst_valid, inst_ready, redirect_valid;
  logic [31:0] imem_req_addr, imem_resp_data, inst, inst_pc, redirect_pc, perf_fetch_cnt, perf_stall_cnt;
  always #5 clk = ~clk;
  ysyx_24120013_ifu dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction
  typedef struct packed {logic [31:0] pc; logic [31:0] data;} exp_t;
  exp_t q[$];
  int rdy_pct = 100, irdy_pct = 100, redir_pct = 0, lat_min = 0, lat_max = 0;
  bit redir_wait = 0, redir_out = 0, run = 0, pend = 0;
  int lat = 0, fcnt = 0;
  logic [31:0] redir_tgt = '0, model_pc = RST_PC, pend_addr = '0;
  // driver, memory model and reference model: the next instruction delivered must be at model_pc
  initial begin
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
    inst_ready = 0; redirect_valid = 0; redirect_pc = 0;
    forever begin
      @(negedge clk); #1;
      imem_resp_valid = 0;
      if (pend) begin
        if (lat == 0) begin
          imem_resp_valid = 1; imem_resp_data = mem_word(pend_addr); pend = 0;
        end else lat--;
      end
      imem_req_ready = $urandom_range(99) < rdy_pct;
      inst_ready     = $urandom_range(99) < irdy_pct;
      redirect_valid = $urandom_range(99) < redir_pct;
      redirect_pc    = $urandom;
      if (redir_wait && pend && !imem_req_valid && !inst_valid) begin
        redirect_valid = 1; redirect_pc = redir_tgt; redir_wait = 0;
      end
      if (redir_out && inst_valid) begin
        redirect_valid = 1; redirect_pc = redir_tgt; inst_ready = 1; redir_out = 0;
      end
      if (!rst) begin
        q.delete(); model_pc = RST_PC; fcnt = 0;
      end else begin
        if (imem_req_valid && imem_req_ready) begin
          pend = 1; lat = $urandom_range(lat_max, lat_min); pend_addr = imem_req_addr;
          if (!redirect_valid) q.push_back({model_pc, mem_word(model_pc)});
        end
        if (redirect_valid) begin
          q.delete(); model_pc = {redirect_pc[31:2], 2'b00};
        end else if (inst_valid && inst_ready) begin
          if (q.size() > 0) void'(q.pop_front());
          model_pc = model_pc + 32'd4; fcnt++;
        end
      end
    end
  end
  // monitor
  always @(negedge clk) if (rst && run) begin
    if (inst_valid) begin
      chk("inst_req_exclusive", {31'd0, imem_req_valid}, 32'd0);
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_inst actual pc %h required no instruction", inst_pc);
      end else begin
        chk("inst_pc", inst_pc, q[0].pc);
        chk("inst", inst, q[0].data);
      end
    end
    if (imem_req_valid) chk("req_addr", imem_req_addr, model_pc);
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, fcnt);
`else
    chk("perf_fetch_tied", perf_fetch_cnt, 32'd0);
    chk("perf_stall_tied", perf_stall_cnt, 32'd0);
`endif
  end
  logic [31:0] h_inst, h_pc, h_cnt;
  int seen;
  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    run = 1;
    #1 rst = 1;
    @(negedge clk); #2;
    chk("c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("c1_req_addr", imem_req_addr, RST_PC);
    @(negedge clk); #2;
    chk("c2_idle", {30'd0, imem_req_valid, inst_valid}, 32'd0);
    @(negedge clk); #2;
    chk("c3_inst_valid", {31'd0, inst_valid}, 32'd1);
    chk("c3_inst_pc", inst_pc, RST_PC);
    @(negedge clk); #2;
    chk("c4_req_addr", imem_req_addr, RST_PC + 32'd4);
    irdy_pct = 0;
    for (int i = 0; i < 20 && !inst_valid; i++) begin @(negedge clk); #2; end
    chk("stall_start", {31'd0, inst_valid}, 32'd1);
    h_inst = inst; h_pc = inst_pc; h_cnt = perf_stall_cnt;
    repeat (5) begin
      @(negedge clk); #2;
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst", inst, h_inst);
      chk("stall_pc", inst_pc, h_pc);
      chk("stall_noreq", {31'd0, imem_req_valid}, 32'd0);
    end
`ifdef IFU_PERF_CNT_EN
    chk("stall_cnt", perf_stall_cnt, h_cnt + 32'd5);
`endif
    rdy_pct = 0; irdy_pct = 100;
    for (int i = 0; i < 20 && !imem_req_valid; i++) begin @(negedge clk); #2; end
    h_pc = imem_req_addr;
    for (int i = 0; i < 4; i++) begin
      chk("hold_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("hold_req_addr", imem_req_addr, h_pc);
      if (i == 2) rdy_pct = 100;
      @(negedge clk); #2;
    end
    chk("hold_accepted", {31'd0, imem_req_valid}, 32'd0);
    lat_min = 2; lat_max = 2; redir_tgt = 32'h8000_0103; redir_wait = 1;
    for (int i = 0; i < 30 && redir_wait; i++) begin @(negedge clk); #2; end
    chk("wait_redirect_issued", {31'd0, redir_wait}, 32'd0);
    seen = 0;
    for (int i = 0; i < 20 && !imem_req_valid; i++) begin
      if (inst_valid) seen++;
      @(negedge clk); #2;
    end
    chk("dropped_not_presented", seen, 32'd0);
    chk("redir_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("redir_req_addr", imem_req_addr, 32'h8000_0100);
    lat_min = 0; lat_max = 0; irdy_pct = 0; redir_tgt = 32'h8000_0200;
    for (int i = 0; i < 20 && !inst_valid; i++) begin @(negedge clk); #2; end
    chk("out_reached", {31'd0, inst_valid}, 32'd1);
    h_cnt = perf_fetch_cnt; redir_out = 1;
    @(negedge clk); #2;
    irdy_pct = 100;
    @(negedge clk); #2;
    chk("out_redir_req_addr", imem_req_addr, 32'h8000_0200);
    chk("out_redir_inst_gone", {31'd0, inst_valid}, 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk("out_redir_fetch_cnt", perf_fetch_cnt, h_cnt);
`endif
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && !imem_req_valid; i++) begin @(negedge clk); #2; end
    @(negedge clk); #2;
    chk("pre_rst_wait", {30'd0, imem_req_valid, inst_valid}, 32'd0);
    #1 rst = 0;
    #1;
    chk("arst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("arst_req_addr", imem_req_addr, 32'd0);
    chk("arst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_inst", inst, 32'd0);
    chk("arst_inst_pc", inst_pc, 32'd0);
    chk("arst_perf_fetch", perf_fetch_cnt, 32'd0);
    chk("arst_perf_stall", perf_stall_cnt, 32'd0);
    repeat (2) @(negedge clk);
    #3 rst = 1;
    @(negedge clk); #2;
    chk("restart_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("restart_req_addr", imem_req_addr, RST_PC);
    lat_min = 0; lat_max = 3; rdy_pct = 70; irdy_pct = 60; redir_pct = 8;
    repeat (3000) @(negedge clk);
    redir_pct = 0;
    repeat (20) @(negedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
